// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 3-bit channel select through the channels
// enabled in mask, ascending with wrap-around, for a one-hot decoder.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         scan enable (level)
//   mask       channel enable, bit i = channel i takes part in the scan
//   dwell      hold time per channel in cycles minus one (sampled live)
//   step_mode  1 = advance on step only, 0 = advance on dwell expiry
//   step       single-cycle advance request (step_mode = 1 only)
//   sel        current channel index (registered)
//   sel_valid  sel is an active, enabled channel (registered)
//   wrap       one-cycle pulse on an advance to an index <= previous
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               step_mode,
    input  logic               step,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               wrap
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [2:0]         nx;
    logic [2:0]         fst;
    logic               adv;

    // Next enabled channel after s, searching s+1..s+7 and then s itself.
    function automatic logic [2:0] nxt_ch(
        input logic [2:0] s,
        input logic [7:0] m
    );
        logic [2:0] j;
        logic       found;
        nxt_ch = s;
        found  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            j = s + 3'(k);
            if (!found && m[j]) begin
                nxt_ch = j;
                found  = 1'b1;
            end
        end
    endfunction

    // Lowest enabled channel; 0 when the mask is empty.
    function automatic logic [2:0] first_ch(input logic [7:0] m);
        first_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) first_ch = 3'(i);
        end
    endfunction

    always_comb begin
        nx  = nxt_ch(sel, mask);
        fst = first_ch(mask);
        adv = step_mode ? step : (cnt >= dwell);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 3'd0;
            sel_valid <= 1'b0;
            wrap      <= 1'b0;
            cnt       <= '0;
        end else begin
            wrap <= 1'b0;
            unique case (state)
                IDLE: begin
                    sel_valid <= 1'b0;
                    if (en && mask != 8'd0) begin
                        sel       <= fst;
                        sel_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (!en || mask == 8'd0) begin
                        state     <= IDLE;
                        sel_valid <= 1'b0;
                        cnt       <= '0;
                    end else if (!mask[sel]) begin
                        // channel dropped mid-dwell: move on, no wrap
                        sel <= nx;
                        cnt <= '0;
                    end else if (adv) begin
                        sel  <= nx;
                        cnt  <= '0;
                        wrap <= (nx <= sel);
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    sel_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: randomized and directed stimulus for scan_sequencer,
// checked cycle by cycle against a behavioural model of the scan rules.
module tb_scan_sequencer;

    localparam int DW   = 8;
    localparam int CMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [7:0]    mask;
    logic [DW-1:0] dwell;
    logic          step_mode;
    logic          step;
    logic [2:0]    sel;
    logic          sel_valid;
    logic          wrap;

    int n_cmp = 0;
    int n_bad = 0;

    // model: active flag, channel, dwell count, wrap pulse
    bit m_act  = 1'b0;
    int m_sel  = 0;
    int m_cnt  = 0;
    bit m_wrap = 1'b0;

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mask      (mask),
        .dwell     (dwell),
        .step_mode (step_mode),
        .step      (step),
        .sel       (sel),
        .sel_valid (sel_valid),
        .wrap      (wrap)
    );

    function automatic int m_next(int s, logic [7:0] m);
        for (int k = 1; k <= 8; k++) begin
            if (m[(s + k) % 8]) return (s + k) % 8;
        end
        return s;
    endfunction

    function automatic int m_first(logic [7:0] m);
        for (int j = 0; j < 8; j++) begin
            if (m[j]) return j;
        end
        return 0;
    endfunction

    // One clock: model consumes the inputs seen at the edge,
    // then returns 1 time unit later so outputs are settled.
    task automatic tick();
        int n;
        @(posedge clk);
        if (!rst_n) begin
            m_act  = 1'b0;
            m_sel  = 0;
            m_cnt  = 0;
            m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (!m_act) begin
                if (en && mask != 8'd0) begin
                    m_act = 1'b1;
                    m_sel = m_first(mask);
                    m_cnt = 0;
                end
            end else if (!en || mask == 8'd0) begin
                m_act = 1'b0;
                m_cnt = 0;
            end else if (!mask[m_sel]) begin
                m_sel = m_next(m_sel, mask);
                m_cnt = 0;
            end else if (step_mode ? step : (m_cnt >= int'(dwell))) begin
                n      = m_next(m_sel, mask);
                m_wrap = (n <= m_sel);
                m_sel  = n;
                m_cnt  = 0;
            end else if (m_cnt < CMAX) begin
                m_cnt++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        mask      = 8'd0;
        dwell     = '0;
        step_mode = 1'b0;
        step      = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({sel, sel_valid, wrap} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset: got sel=%0d v=%0b w=%0b want 0/0/0",
                     sel, sel_valid, wrap);
        end
    endtask

    task automatic test_full_scan();
        rst_n = 1'b1;
        en    = 1'b1;
        mask  = 8'hFF;
        dwell = 8'd2;
        for (int i = 1; i <= 30; i++) begin
            tick();
            n_cmp++;
            if ({sel, sel_valid, wrap} !== {3'(m_sel), m_act, m_wrap}) begin
                n_bad++;
                $display("FAIL full_scan c%0d: got %0d/%0b/%0b want %0d/%0b/%0b",
                         i, sel, sel_valid, wrap, m_sel, m_act, m_wrap);
            end
            if (i == 1 || i == 25) begin
                n_cmp++;
                if ({sel, sel_valid, wrap} !== {3'd0, 1'b1, i == 25}) begin
                    n_bad++;
                    $display("FAIL full_scan_edge c%0d: got %0d/%0b/%0b want 0/1/%0b",
                             i, sel, sel_valid, wrap, i == 25);
                end
            end
        end
    endtask

    task automatic test_sparse();
        int wraps = 0;
        mask  = 8'b1010_0100;
        dwell = 8'd0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (wrap) wraps++;
            n_cmp++;
            if ({sel, sel_valid, wrap} !== {3'(m_sel), m_act, m_wrap}) begin
                n_bad++;
                $display("FAIL sparse c%0d: got %0d/%0b/%0b want %0d/%0b/%0b",
                         i, sel, sel_valid, wrap, m_sel, m_act, m_wrap);
            end
        end
        n_cmp++;
        if (wraps < 5 || wraps > 7) begin
            n_bad++;
            $display("FAIL sparse_wraps: got %0d want 5..7", wraps);
        end
    endtask

    task automatic test_step();
        en = 1'b0;
        tick();
        en        = 1'b1;
        step_mode = 1'b1;
        dwell     = 8'd0;
        mask      = 8'hFF;
        tick();
        for (int c = 1; c <= 12; c++) begin
            step = (c == 5 || c == 9);
            tick();
            step = 1'b0;
            n_cmp++;
            if ({sel, sel_valid, wrap} !== {3'(m_sel), m_act, m_wrap}) begin
                n_bad++;
                $display("FAIL step c%0d: got %0d/%0b/%0b want %0d/%0b/%0b",
                         c, sel, sel_valid, wrap, m_sel, m_act, m_wrap);
            end
        end
        n_cmp++;
        if (sel !== 3'd2) begin
            n_bad++;
            $display("FAIL step_final: got sel=%0d want 2", sel);
        end
    endtask

    task automatic test_mask_clear();
        bit hit = 1'b0;
        step_mode = 1'b0;
        dwell     = 8'd0;
        mask      = 8'hFF;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            hit = m_act && m_sel == 3;
        end
        n_cmp++;
        if (!hit || sel !== 3'd3) begin
            n_bad++;
            $display("FAIL mask_clear_reach3: got sel=%0d want 3", sel);
        end
        dwell = 8'd10;
        hit   = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (m_cnt == 4) hit = 1'b1;
            else tick();
        end
        mask = 8'hF7;
        tick();
        n_cmp++;
        if ({sel, sel_valid, wrap} !== {3'd4, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL mask_clear_skip: got %0d/%0b/%0b want 4/1/0",
                     sel, sel_valid, wrap);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({sel, sel_valid, wrap} !== {3'(m_sel), m_act, m_wrap}) begin
                n_bad++;
                $display("FAIL mask_clear_hold c%0d: got %0d/%0b/%0b want %0d/%0b/%0b",
                         i, sel, sel_valid, wrap, m_sel, m_act, m_wrap);
            end
        end
        n_cmp++;
        if (sel !== 3'd4) begin
            n_bad++;
            $display("FAIL mask_clear_hold11: got sel=%0d want 4", sel);
        end
        tick();
        n_cmp++;
        if (sel !== 3'd5) begin
            n_bad++;
            $display("FAIL mask_clear_adv: got sel=%0d want 5", sel);
        end
        mask = 8'd0;
        tick();
        n_cmp++;
        if (sel_valid !== 1'b0 || sel_valid !== m_act) begin
            n_bad++;
            $display("FAIL mask_zero: got v=%0b want 0", sel_valid);
        end
    endtask

    task automatic test_single();
        int wraps = 0;
        mask  = 8'b0001_0000;
        dwell = 8'd1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (wrap) wraps++;
            n_cmp++;
            if ({sel, sel_valid, wrap} !== {3'(m_sel), m_act, m_wrap}
                || sel !== 3'd4) begin
                n_bad++;
                $display("FAIL single c%0d: got %0d/%0b/%0b want %0d/%0b/%0b",
                         i, sel, sel_valid, wrap, m_sel, m_act, m_wrap);
            end
        end
        n_cmp++;
        if (wraps != 5) begin
            n_bad++;
            $display("FAIL single_wraps: got %0d want 5", wraps);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        mask  = 8'b0100_0110;
        dwell = 8'd3;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            hit = m_act && m_sel == 6 && m_cnt == 3;
        end
        n_cmp++;
        if (!hit || sel !== 3'd6) begin
            n_bad++;
            $display("FAIL reset_mid_reach6: got sel=%0d want 6", sel);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({sel, sel_valid, wrap} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_mid: got %0d/%0b/%0b want 0/0/0",
                     sel, sel_valid, wrap);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({sel, sel_valid, wrap} !== {3'd1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_restart: got %0d/%0b/%0b want 1/1/0",
                     sel, sel_valid, wrap);
        end
    endtask

    task automatic test_saturation();
        mask      = 8'hFF;
        step_mode = 1'b1;
        step      = 1'b0;
        dwell     = 8'd0;
        for (int i = 0; i < 300; i++) tick();
        n_cmp++;
        if ({sel, sel_valid} !== {3'(m_sel), m_act}) begin
            n_bad++;
            $display("FAIL sat_hold: got %0d/%0b want %0d/%0b",
                     sel, sel_valid, m_sel, m_act);
        end
        step_mode = 1'b0;
        dwell     = 8'hFF;
        tick();
        n_cmp++;
        if ({sel, sel_valid, wrap} !== {3'(m_sel), m_act, m_wrap}
            || m_cnt != 0) begin
            n_bad++;
            $display("FAIL sat_expire: got %0d/%0b/%0b want %0d/%0b/%0b",
                     sel, sel_valid, wrap, m_sel, m_act, m_wrap);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            en    = ($urandom_range(0, 31) != 0);
            if ($urandom_range(0, 15) == 0)
                mask = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 7) == 0)
                dwell = DW'($urandom_range(0, 5));
            if ($urandom_range(0, 31) == 0)
                step_mode = ~step_mode;
            step = 1'($urandom);
            tick();
            n_cmp++;
            if ({sel, sel_valid, wrap} !== {3'(m_sel), m_act, m_wrap}) begin
                n_bad++;
                $display("FAIL random c%0d: got %0d/%0b/%0b want %0d/%0b/%0b",
                         i, sel, sel_valid, wrap, m_sel, m_act, m_wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_sparse();
        test_step();
        test_mask_clear();
        test_single();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
